register_file: RTL and testbench



---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_read_port.sv | 35 +++
 rtl/register_file.sv | 63 ++++++
 tb/tb_register_file.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32 x 32-bit general-purpose register file.
package regfile_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ZERO_REG = 0;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address mux over the storage array, register-0 override
// and, when REGFILE_WRITE_BYPASS_EN is defined, same-cycle forwarding of the pending write.
module regfile_read_port #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]                  raddr,
`ifdef REGFILE_WRITE_BYPASS_EN
    input  logic                               rst,
    input  logic                               wen,
    input  logic [ADDR_W-1:0]                  waddr,
    input  logic [DATA_W-1:0]                  wdata,
`endif
    output logic [DATA_W-1:0]                  rdata
);
    import regfile_pkg::*;

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    // Select stored word; register 0 always reads zero, even before the first reset.
    always_comb begin
        rdata = regs[raddr];
`ifdef REGFILE_WRITE_BYPASS_EN
        // Forward the write that will commit at the next edge; reset cancels that write.
        if (wen && !rst && (waddr != ZERO_ADDR) && (raddr == waddr)) begin
            rdata = wdata;
        end
`endif
        if (raddr == ZERO_ADDR) begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file, 2**ADDR_W entries of DATA_W bits, register 0 hardwired
// to zero. Optional write-to-read forwarding is enabled by defining REGFILE_WRITE_BYPASS_EN.
module register_file #(
    parameter int unsigned DATA_W = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              wen
);
    import regfile_pkg::*;

    localparam int unsigned       NREGS     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [NREGS-1:0][DATA_W-1:0] mem;

    // Storage update: reset clears every entry and wins over a coincident write.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '0;
        end else if (wen && (waddr != ZERO_ADDR)) begin
            mem[waddr] <= wdata;
        end
    end

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_read_port1 (
        .regs  (mem),
        .raddr (raddr1),
`ifdef REGFILE_WRITE_BYPASS_EN
        .rst   (rst),
        .wen   (wen),
        .waddr (waddr),
        .wdata (wdata),
`endif
        .rdata (rdata1)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_read_port2 (
        .regs  (mem),
        .raddr (raddr2),
`ifdef REGFILE_WRITE_BYPASS_EN
        .rst   (rst),
        .wen   (wen),
        .waddr (waddr),
        .wdata (wdata),
`endif
        .rdata (rdata2)
    );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected read data, a monitor on the
// falling edge pops and compares against both read ports.
module tb_register_file;
    import regfile_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    reg_addr_t waddr;
    reg_data_t wdata;
    reg_addr_t raddr1;
    reg_data_t rdata1;
    reg_addr_t raddr2;
    reg_data_t rdata2;
    logic      wen;

    typedef struct {
        int        port;
        reg_data_t exp;
        string     name;
    } exp_t;

    exp_t scb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    register_file dut (
        .clk    (clk),
        .rst    (rst),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .raddr2 (raddr2),
        .rdata2 (rdata2),
        .wen    (wen)
    );

    always #5 clk = ~clk;

    // Monitor: read data is valid mid-cycle; drain everything queued for this cycle.
    always @(negedge clk) begin
        while (scb.size() > 0) begin
            exp_t e;
            reg_data_t got;
            e   = scb.pop_front();
            got = (e.port == 1) ? rdata1 : rdata2;
            n_vec++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s port%0d: got %h expected %h", e.name, e.port, got, e.exp);
            end
        end
    end

    task automatic push(input int port, input reg_data_t v, input string nm);
        exp_t e;
        e.port = port;
        e.exp  = v;
        e.name = nm;
        scb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Set read addresses, queue both expectations, advance one cycle.
    task automatic rd(input reg_addr_t a1, input reg_data_t e1, input reg_addr_t a2,
                      input reg_data_t e2, input string nm);
        raddr1 = a1;
        raddr2 = a2;
        push(1, e1, nm);
        push(2, e2, nm);
        step();
    endtask

    initial begin
        reg_data_t same_cycle_exp;
        rst    = 1'b1;
        wen    = 1'b0;
        waddr  = '0;
        wdata  = '0;
        raddr1 = '0;
        raddr2 = '0;
        step();
        rst = 1'b0;

        // Everything reads zero after reset.
        for (int a = 0; a < 32; a++) begin
            rd(reg_addr_t'(a), 32'd0, reg_addr_t'(31 - a), 32'd0, "reset_sweep");
        end

        // Basic write then read.
        wen = 1'b1; waddr = 5'd15; wdata = 32'd1234;
        step();
        wen = 1'b0;
        rd(5'd15, 32'd1234, 5'd0, 32'd0, "write15");

        wen = 1'b1; waddr = 5'd30; wdata = 32'd56781;
        step();
        wen = 1'b0;
        rd(5'd30, 32'd56781, 5'd15, 32'd1234, "write30");

        // wen low must not modify storage.
        waddr = 5'd15; wdata = 32'd999;
        rd(5'd15, 32'd1234, 5'd30, 32'd56781, "wen_gate_pre");
        rd(5'd15, 32'd1234, 5'd15, 32'd1234, "wen_gate_post");

        // Writes to register 0 are discarded, and it never forwards.
        wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        rd(5'd0, 32'd0, 5'd0, 32'd0, "zero_reg_pre");
        wen = 1'b0;
        rd(5'd0, 32'd0, 5'd0, 32'd0, "zero_reg_post");

        // Boundary entries 1 and 31, both ports on the same register.
        wen = 1'b1; waddr = 5'd31; wdata = 32'hDEAD_BEEF;
        step();
        waddr = 5'd1; wdata = 32'h0000_0001;
        step();
        wen = 1'b0;
        rd(5'd31, 32'hDEAD_BEEF, 5'd31, 32'hDEAD_BEEF, "reg31_both");
        rd(5'd1, 32'h0000_0001, 5'd31, 32'hDEAD_BEEF, "reg1");

        // Same-cycle read of the address being written.
`ifdef REGFILE_WRITE_BYPASS_EN
        same_cycle_exp = 32'd77;
`else
        same_cycle_exp = 32'd0;
`endif
        wen = 1'b1; waddr = 5'd5; wdata = 32'd77;
        rd(5'd5, same_cycle_exp, 5'd15, 32'd1234, "same_cycle_pre");
        wen = 1'b0;
        rd(5'd5, 32'd77, 5'd30, 32'd56781, "same_cycle_post");

        // Reset beats a coincident write and clears earlier writes.
        rst = 1'b1; wen = 1'b1; waddr = 5'd7; wdata = 32'd42;
        rd(5'd7, 32'd0, 5'd15, 32'd1234, "rst_prio_pre");
        rst = 1'b0; wen = 1'b0;
        rd(5'd7, 32'd0, 5'd15, 32'd0, "rst_prio_7_15");
        rd(5'd30, 32'd0, 5'd5, 32'd0, "rst_prio_30_5");
        rd(5'd31, 32'd0, 5'd1, 32'd0, "rst_prio_31_1");

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 5 && scb.size() > 0; i++) step();
        if (scb.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", scb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
